// File: rtl/mem8_arbiter.sv
// mem8_arbiter: shares one 8-bit single-port memory between the core
// and a host burst engine; core first, host bursts run in idle cycles.
module mem8_arbiter #(
  parameter int ASZ    = 17,
  parameter int LSZ    = 12,
  parameter int STARVE = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           core_req,
  input  logic           core_we,
  input  logic [ASZ-1:0] core_addr,
  input  logic [7:0]     core_wdata,
  output logic [7:0]     core_rdata,
  output logic           core_hold,
  input  logic           host_start,
  input  logic           host_we,
  input  logic [ASZ-1:0] host_addr,
  input  logic [LSZ-1:0] host_len,
  input  logic [7:0]     host_wdata,
  output logic           host_wack,
  output logic [7:0]     host_rdata,
  output logic           host_rvalid,
  output logic           host_busy,
  output logic           host_done,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_addr,
  output logic [7:0]     mem_wdata,
  input  logic [7:0]     mem_rdata
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  state_t         state_d;
  logic [ASZ-1:0] b_addr;
  logic [ASZ-1:0] addr_q;
  logic [LSZ-1:0] b_left;
  logic           b_we;
  logic [CW-1:0]  cnt;
  logic           force_q;
  logic           done_q;
  logic           core_rd_q;
  logic           host_rd_q;
  logic [7:0]     core_rdata_q;

  logic core_win;
  logic host_beat;
  logic last_beat;
  logic start_ok;
  logic start_nil;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state: a new burst may start whenever no burst is active
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DRAIN: state_d = start_ok ? BURST : IDLE;
      BURST: if (last_beat) state_d = b_we ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: per-cycle grant, core first unless a forced stall is due
  always_comb begin
    core_win  = rst & core_req & ~force_q;
    host_beat = rst & (state == BURST) & ~core_win;
    last_beat = host_beat & (b_left == LSZ'(1));
    start_ok  = rst & host_start & (state != BURST)
              & (host_len != '0);
    start_nil = rst & host_start & (state != BURST)
              & (host_len == '0);
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    host_wack = 1'b0;
    unique case (1'b1)
      core_win: begin
        mem_addr  = core_addr;
        mem_we    = core_we;
        mem_wdata = core_wdata;
      end
      host_beat: begin
        mem_addr  = b_addr;
        mem_we    = b_we;
        mem_wdata = b_we ? host_wdata : '0;
        host_wack = b_we;
      end
      default: ;
    endcase
    core_hold   = force_q & core_req;
    host_busy   = (state == BURST);
    host_done   = done_q;
    host_rvalid = host_rd_q;
    host_rdata  = host_rd_q ? mem_rdata : '0;
    core_rdata  = core_rd_q ? mem_rdata : core_rdata_q;
  end

  // Burst registers, starvation counter and read-return tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_addr       <= '0;
      b_left       <= '0;
      b_we         <= 1'b0;
      cnt          <= '0;
      force_q      <= 1'b0;
      done_q       <= 1'b0;
      core_rd_q    <= 1'b0;
      host_rd_q    <= 1'b0;
      core_rdata_q <= '0;
      addr_q       <= '0;
    end else begin
      if (start_ok) begin
        b_addr <= host_addr;
        b_left <= host_len;
        b_we   <= host_we;
      end else if (host_beat) begin
        b_addr <= b_addr + ASZ'(1);
        b_left <= b_left - LSZ'(1);
      end
      if (host_beat)
        cnt <= '0;
      else if (state == BURST && core_win && cnt != CMAX)
        cnt <= cnt + CW'(1);
      force_q      <= (state == BURST) & core_win & (cnt == CMAX);
      done_q       <= last_beat | start_nil;
      core_rd_q    <= core_win & ~core_we;
      host_rd_q    <= host_beat & ~b_we;
      core_rdata_q <= core_rdata;
      addr_q       <= mem_addr;
    end
  end

endmodule

// File: tb/tb_mem8_arbiter.sv
// tb_mem8_arbiter: directed vectors against a behavioural
// one-cycle-latency byte memory.
module tb_mem8_arbiter;

  localparam int ASZ = 17;
  localparam int LSZ = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           core_req = 1'b0;
  logic           core_we = 1'b0;
  logic [ASZ-1:0] core_addr = '0;
  logic [7:0]     core_wdata = '0;
  logic [7:0]     core_rdata;
  logic           core_hold;
  logic           host_start = 1'b0;
  logic           host_we = 1'b0;
  logic [ASZ-1:0] host_addr = '0;
  logic [LSZ-1:0] host_len = '0;
  logic [7:0]     host_wdata = '0;
  logic           host_wack;
  logic [7:0]     host_rdata;
  logic           host_rvalid;
  logic           host_busy;
  logic           host_done;
  logic           mem_we;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_rdata = '0;

  logic [7:0]     mem [0:(1<<ASZ)-1];
  logic           pre_we = 1'b0;
  logic [ASZ-1:0] pre_addr = '0;
  logic [7:0]     pre_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  mem8_arbiter #(.ASZ(ASZ), .LSZ(LSZ), .STARVE(8)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_hold(core_hold),
    .host_start(host_start), .host_we(host_we),
    .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_wack(host_wack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_busy(host_busy), .host_done(host_done),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [ASZ-1:0] a,
                      input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    cyc();
    pre_we   = 1'b0;
  endtask

  initial begin
    logic hold_e;
    logic rv_e;
    int   beat;
    int   rv;

    // reset state, with core inputs active
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 17'h155;
    core_wdata = 8'hFF;
    #1;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_hold", 32'(core_hold), 0);
    chk("rst_busy", 32'(host_busy), 0);
    chk("rst_done", 32'(host_done), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_core_rdata", 32'(core_rdata), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    core_req = 1'b0;
    core_we  = 1'b0;
    poke(17'h1400, 8'hA0);
    poke(17'h1401, 8'hA1);
    poke(17'h1402, 8'hA2);
    poke(17'h2000, 8'hB0);
    poke(17'h2001, 8'hB1);
    poke(17'h2002, 8'hB2);
    poke(17'h0100, 8'h77);
    rst = 1'b1;
    cyc();

    // write burst, core idle
    host_start = 1'b1;
    host_we    = 1'b1;
    host_addr  = 17'h1000;
    host_len   = 12'd4;
    host_wdata = 8'h41;
    @(negedge clk);
    chk("t1_busy0", 32'(host_busy), 0);
    cyc();
    host_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_wdata = 8'(8'h41 + i);
      @(negedge clk);
      chk("t1_wack", 32'(host_wack), 1);
      chk("t1_we", 32'(mem_we), 1);
      chk("t1_addr", 32'(mem_addr), 32'h1000 + i);
      chk("t1_wdata", 32'(mem_wdata), 32'h41 + i);
      chk("t1_busy", 32'(host_busy), 1);
      cyc();
    end
    @(negedge clk);
    chk("t1_done", 32'(host_done), 1);
    chk("t1_busy_off", 32'(host_busy), 0);
    chk("t1_we_off", 32'(mem_we), 0);
    cyc();
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 17'h1002;
    @(negedge clk);
    chk("t1_core_addr", 32'(mem_addr), 32'h1002);
    chk("t1_done_pulse", 32'(host_done), 0);
    cyc();
    core_req = 1'b0;
    @(negedge clk);
    chk("t1_core_rdata", 32'(core_rdata), 32'h43);
    cyc();

    // read burst, core idle
    host_start = 1'b1;
    host_we    = 1'b0;
    host_addr  = 17'h1400;
    host_len   = 12'd3;
    cyc();
    host_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t2_rvalid", 32'(host_rvalid), 32'(k >= 2));
      if (k >= 2)
        chk("t2_rdata", 32'(host_rdata), 32'hA0 + k - 2);
      if (k < 4)
        chk("t2_addr", 32'(mem_addr), 32'h1400 + k - 1);
      chk("t2_done", 32'(host_done), 32'(k == 4));
      chk("t2_busy", 32'(host_busy), 32'(k < 4));
      cyc();
    end

    // starvation: core requests continuously during a read burst
    host_start = 1'b1;
    host_we    = 1'b0;
    host_addr  = 17'h2000;
    host_len   = 12'd3;
    core_req   = 1'b1;
    core_wdata = 8'h5A;
    beat = 0;
    rv   = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) host_start = 1'b0;
      core_we   = (c == 9 || c == 10);
      core_addr = core_we ? 17'h0300 : 17'h0100;
      @(negedge clk);
      hold_e = (c == 9 || c == 18 || c == 27);
      rv_e   = (c == 10 || c == 19 || c == 28);
      chk("t3_hold", 32'(core_hold), 32'(hold_e));
      if (hold_e) begin
        chk("t3_host_addr", 32'(mem_addr), 32'h2000 + beat);
        chk("t3_hold_we", 32'(mem_we), 0);
        beat++;
      end else begin
        chk("t3_core_addr", 32'(mem_addr), 32'(core_addr));
      end
      if (c == 10) chk("t3_replay_we", 32'(mem_we), 1);
      chk("t3_rvalid", 32'(host_rvalid), 32'(rv_e));
      if (rv_e) begin
        chk("t3_rdata", 32'(host_rdata), 32'hB0 + rv);
        rv++;
      end
      chk("t3_done", 32'(host_done), 32'(c == 28));
      if (c == 2) chk("t3_core_rdata", 32'(core_rdata), 32'h77);
      cyc();
    end
    core_req = 1'b0;
    core_we  = 1'b0;
    chk("t3_core_wr", 32'(mem[17'h0300]), 32'h5A);

    // address wrap
    host_start = 1'b1;
    host_we    = 1'b1;
    host_addr  = 17'h1FFFF;
    host_len   = 12'd2;
    host_wdata = 8'hC1;
    cyc();
    host_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      host_wdata = 8'(8'hC1 + i);
      @(negedge clk);
      chk("t4_addr", 32'(mem_addr), (i == 0) ? 32'h1FFFF : 32'h0);
      chk("t4_wack", 32'(host_wack), 1);
      cyc();
    end
    @(negedge clk);
    chk("t4_done", 32'(host_done), 1);
    cyc();
    chk("t4_mem_hi", 32'(mem[17'h1FFFF]), 32'hC1);
    chk("t4_mem_lo", 32'(mem[17'h00000]), 32'hC2);

    // zero length
    host_start = 1'b1;
    host_len   = 12'd0;
    host_addr  = 17'h0500;
    @(negedge clk);
    chk("t5_z_we0", 32'(mem_we), 0);
    cyc();
    host_start = 1'b0;
    @(negedge clk);
    chk("t5_z_done", 32'(host_done), 1);
    chk("t5_z_busy", 32'(host_busy), 0);
    chk("t5_z_we", 32'(mem_we), 0);
    chk("t5_z_wack", 32'(host_wack), 0);
    cyc();

    // start while busy is ignored
    host_start = 1'b1;
    host_we    = 1'b1;
    host_addr  = 17'h3000;
    host_len   = 12'd2;
    host_wdata = 8'hD1;
    cyc();
    host_we    = 1'b0;
    host_addr  = 17'h3800;
    host_len   = 12'd5;
    @(negedge clk);
    chk("t5_b_addr0", 32'(mem_addr), 32'h3000);
    chk("t5_b_wdata0", 32'(mem_wdata), 32'hD1);
    cyc();
    host_start = 1'b0;
    host_wdata = 8'hD2;
    @(negedge clk);
    chk("t5_b_addr1", 32'(mem_addr), 32'h3001);
    chk("t5_b_we1", 32'(mem_we), 1);
    cyc();
    @(negedge clk);
    chk("t5_b_done", 32'(host_done), 1);
    chk("t5_b_busy", 32'(host_busy), 0);
    cyc();
    @(negedge clk);
    chk("t5_b_idle", 32'(host_busy), 0);
    chk("t5_b_done0", 32'(host_done), 0);
    cyc();

    // reset mid-burst
    host_start = 1'b1;
    host_we    = 1'b1;
    host_addr  = 17'h4000;
    host_len   = 12'd8;
    host_wdata = 8'hE0;
    cyc();
    host_start = 1'b0;
    @(negedge clk);
    chk("t6_beat1", 32'(mem_addr), 32'h4000);
    cyc();
    host_wdata = 8'hE1;
    #2;
    chk("t6_beat2", 32'(host_wack), 1);
    rst = 1'b0;
    #1;
    chk("t6_r_wack", 32'(host_wack), 0);
    chk("t6_r_busy", 32'(host_busy), 0);
    chk("t6_r_we", 32'(mem_we), 0);
    chk("t6_r_addr", 32'(mem_addr), 0);
    chk("t6_r_wdata", 32'(mem_wdata), 0);
    chk("t6_r_done", 32'(host_done), 0);
    cyc();
    chk("t6_r_done2", 32'(host_done), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rel_done", 32'(host_done), 0);
    chk("t6_rel_busy", 32'(host_busy), 0);
    chk("t6_rel_we", 32'(mem_we), 0);
    cyc();
    host_start = 1'b1;
    host_we    = 1'b1;
    host_addr  = 17'h4100;
    host_len   = 12'd1;
    host_wdata = 8'h99;
    cyc();
    host_start = 1'b0;
    @(negedge clk);
    chk("t6_n_wack", 32'(host_wack), 1);
    chk("t6_n_addr", 32'(mem_addr), 32'h4100);
    cyc();
    @(negedge clk);
    chk("t6_n_done", 32'(host_done), 1);
    chk("t6_n_busy", 32'(host_busy), 0);
    cyc();
    chk("t6_n_mem", 32'(mem[17'h4100]), 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem8_arbiter.md
Name: mem8_arbiter

Overview:
- Arbitrates the single-port 8-bit memory (spram8_128k behind mb8_io) between the eJ32 core and a host burst port.
- The host port is used by the dictionary loader, by memory dump, and by output-buffer drain logic.
- The core has priority. The host moves data in auto-incrementing bursts in cycles the core leaves idle.
- A starvation counter forces a one-cycle core stall so that host bursts always make progress.

Parameters:
ASZ, 17, byte address width (128K space)
LSZ, 12, burst length counter width (max burst 4095 bytes)
STARVE, 8, consecutive denied host cycles before a core stall is forced (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  core memory access this cycle
core_we  in  1  core write strobe
core_addr  in  ASZ  core byte address
core_wdata  in  8  core write data
core_rdata  out  8  read data, valid one cycle after an accepted core read
core_hold  out  1  core must stall and repeat its current access
host_start  in  1  one-cycle pulse: latch a burst command; ignored while host_busy
host_we  in  1  burst direction (1 = write to memory)
host_addr  in  ASZ  burst start address
host_len  in  LSZ  burst length in bytes; 0 = no-op
host_wdata  in  8  write byte, consumed when host_wack=1
host_wack  out  1  host write byte consumed this cycle
host_rdata  out  8  read byte
host_rvalid  out  1  host_rdata valid this cycle
host_busy  out  1  burst in progress
host_done  out  1  one-cycle pulse when the last beat completes
mem_we  out  1  memory write strobe
mem_addr  out  ASZ  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, one cycle latency

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0: core_hold, host_busy, host_done, host_wack, host_rvalid, mem_we, mem_addr, mem_wdata, core_rdata, host_rdata.
  - Starvation counter and burst registers are cleared.
  - Reset mid-burst abandons the burst. No host_done is issued.
- States:
  - IDLE → BURST on host_start with host_len≠0. This latches addr, len, and we, and sets host_busy the next cycle.
  - host_start with host_len=0 gives a host_done pulse the next cycle and stays in IDLE.
  - BURST → DRAIN after the last beat is issued, if it was a read. It goes directly to IDLE if it was a write.
  - DRAIN → IDLE after one cycle.
  - host_done pulses on the cycle host_busy falls.
    - For reads, this is the cycle the final host_rvalid is asserted.
    - For writes, this is the cycle after the final host_wack.
- Per-cycle grant, combinational from registered state:
  - If core_req=1, core_hold=0, and no force is pending: the core owns memory. mem_addr/mem_we/mem_wdata = core signals.
  - Otherwise, in BURST: a host beat is issued.
    - mem_addr = burst address. Address increments by 1 per beat, wrapping modulo 2^ASZ.
    - For writes, mem_we=1, mem_wdata=host_wdata, host_wack=1.
  - Otherwise: mem_we=0 and mem_addr holds its last value.
- Starvation:
  - The counter increments each BURST cycle in which the core wins. It clears on any host beat.
  - When counter == STARVE-1, the next cycle asserts core_hold=1 and the host takes that beat.
  - The counter then clears. core_hold is never asserted for two consecutive cycles.
  - core_hold is asserted only while core_req=1.
- Read return: the owner of each read is registered. One cycle later, mem_rdata is routed as follows.
  - Core read: goes to core_rdata.
  - Host read: goes to host_rdata with host_rvalid=1.
  - core_rdata holds its value in all other cycles.
- Held core access:
  - On a core_hold cycle, the core's access is not performed. No core write occurs.
  - The core re-presents the identical access next cycle.
- Simultaneous host_start and core_req in IDLE: the core is granted and the burst latches. The first host beat waits for a free cycle or a starvation force.
- host_wdata must be valid whenever host_busy=1 and host_we=1. The host advances to the next byte only on host_wack.

Test Plan:
- Host write burst, core idle: host_addr=0x1000, len=4, bytes 41 42 43 44.
  - Expect 4 consecutive host_wack, mem_addr 0x1000..0x1003, mem_we=1.
  - host_done on the 5th cycle. A subsequent core read of 0x1002 returns 0x43.
- Host read burst, core idle: addr=0x1400, len=3.
  - Expect host_rvalid on cycles 2,3,4 with stored data, and host_done coinciding with the third rvalid.
- Starvation: core_req held at 1 for 40 cycles during a len=3 read burst with STARVE=8.
  - Expect core_hold pulses on cycles 9, 18, 27 after start, one host beat each, and no consecutive holds.
  - The core access stalled on a hold completes on the following cycle.
- Address wrap: host write at addr=0x1FFFF, len=2.
  - Expect mem_addr 0x1FFFF then 0x00000, and host_done asserted.
- Zero-length and busy: host_start with len=0 → host_done only, no mem access.
  - host_start while busy is ignored, and the original burst completes unchanged.
- Reset mid-burst: drop rst low during beat 2 of a len=8 write.
  - All outputs go to 0 immediately, with no host_done.
  - After release, a new len=1 burst completes normally.
